// File: rtl/y86_decode_stage_pkg.sv
// rtl/y86_decode_stage_pkg.sv - shared Y86 icodes, register IDs and E-register bubble constants
package y86_define;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] R_ESP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    typedef struct packed {
        logic       valid;
        logic [3:0] icode;
        logic [3:0] ifun;
    } e_ctl_t;

    localparam e_ctl_t E_CTL_BUBBLE = '{valid: 1'b0, icode: I_NOP, ifun: 4'h0};

    function automatic logic is_load(input logic [3:0] icode);
        return (icode == I_MRMOVL) || (icode == I_POPL);
    endfunction

endpackage

// File: rtl/y86_decode_stage_if.sv
// rtl/y86_decode_stage_if.sv - D-register (fetch->decode) and E-register (decode->execute) bundles
interface y86_dreg_if #(parameter int XLEN = 32, parameter int RID_W = 4);
    logic             d_valid;
    logic             d_ready;
    logic [3:0]       d_icode;
    logic [3:0]       d_ifun;
    logic [RID_W-1:0] d_rA;
    logic [RID_W-1:0] d_rB;
    logic [XLEN-1:0]  d_valC;
    logic [XLEN-1:0]  d_valP;

    modport master (output d_valid, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, input d_ready);
    modport slave  (input d_valid, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, output d_ready);
endinterface

interface y86_ereg_if #(parameter int XLEN = 32, parameter int RID_W = 4);
    logic             e_valid;
    logic             e_ready;
    logic [3:0]       e_icode;
    logic [3:0]       e_ifun;
    logic [XLEN-1:0]  e_valC;
    logic [XLEN-1:0]  e_valA;
    logic [XLEN-1:0]  e_valB;
    logic [RID_W-1:0] e_srcA;
    logic [RID_W-1:0] e_srcB;
    logic [RID_W-1:0] e_dstE;
    logic [RID_W-1:0] e_dstM;

    modport master (output e_valid, e_icode, e_ifun, e_valC, e_valA, e_valB,
                    e_srcA, e_srcB, e_dstE, e_dstM, input e_ready);
    modport slave  (input e_valid, e_icode, e_ifun, e_valC, e_valA, e_valB,
                    e_srcA, e_srcB, e_dstE, e_dstM, output e_ready);
endinterface

// File: rtl/y86_decode_stage_regfile.sv
// rtl/y86_decode_stage_regfile.sv - NREG x XLEN register file, 2 comb reads, 2 writes with M over E
module y86_regfile_p #(
    parameter int XLEN  = 32,
    parameter int NREG  = 8,
    parameter int RID_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [RID_W-1:0] rd_a_id,
    output logic [XLEN-1:0]  rd_a_data,
    input  logic [RID_W-1:0] rd_b_id,
    output logic [XLEN-1:0]  rd_b_data,
    input  logic [RID_W-1:0] wr_e_id,
    input  logic [XLEN-1:0]  wr_e_data,
    input  logic [RID_W-1:0] wr_m_id,
    input  logic [XLEN-1:0]  wr_m_data
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // IDs outside 0..NREG-1 (R_NONE included) never match, so they neither write nor read.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_e_id == RID_W'(i)) regs_d[i] = wr_e_data;
            if (wr_m_id == RID_W'(i)) regs_d[i] = wr_m_data;
        end
    end

    always_comb begin
        rd_a_data = '0;
        rd_b_data = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_a_id == RID_W'(i)) rd_a_data = regs_q[i];
            if (rd_b_id == RID_W'(i)) rd_b_data = regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!resetn) regs_q[i] <= '0;
            else         regs_q[i] <= regs_d[i];
        end
    end

endmodule

// File: rtl/y86_decode_stage.sv
// rtl/y86_decode_stage.sv - Y86 decode: regfile, E/M/W forwarding, load-use stall, D/E pipeline register
module y86_decode_stage
    import y86_define::*;
#(
    parameter int XLEN  = 32,
    parameter int NREG  = 8,
    parameter int RID_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    y86_dreg_if.slave        dreg,
    input  logic [RID_W-1:0] e_dstE,
    input  logic [XLEN-1:0]  e_valE,
    input  logic [RID_W-1:0] m_dstE,
    input  logic [XLEN-1:0]  m_valE,
    input  logic [RID_W-1:0] m_dstM,
    input  logic [XLEN-1:0]  m_valM,
    input  logic [RID_W-1:0] w_dstE,
    input  logic [XLEN-1:0]  w_valE,
    input  logic [RID_W-1:0] w_dstM,
    input  logic [XLEN-1:0]  w_valM,
    input  logic             flush,
    y86_ereg_if.master       ereg,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [RID_W-1:0] RN   = RID_W'(R_NONE);
    localparam logic [RID_W-1:0] RESP = RID_W'(R_ESP);

    logic [RID_W-1:0] src_a, src_b, dst_e, dst_m;
    logic [XLEN-1:0]  rf_a, rf_b, val_a, val_b;
    logic             lu, d_ready_c;

    e_ctl_t           ctl_q, ctl_d;
    logic [XLEN-1:0]  valc_q, valc_d, vala_q, vala_d, valb_q, valb_d;
    logic [RID_W-1:0] srca_q, srca_d, srcb_q, srcb_d, dste_q, dste_d, dstm_q, dstm_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        src_a = RN;
        src_b = RN;
        dst_e = RN;
        dst_m = RN;
        case (dreg.d_icode)
            I_RRMOVL: begin src_a = dreg.d_rA; dst_e = dreg.d_rB; end
            I_IRMOVL: dst_e = dreg.d_rB;
            I_RMMOVL: begin src_a = dreg.d_rA; src_b = dreg.d_rB; end
            I_MRMOVL: begin src_b = dreg.d_rB; dst_m = dreg.d_rA; end
            I_OPL:    begin src_a = dreg.d_rA; src_b = dreg.d_rB; dst_e = dreg.d_rB; end
            I_PUSHL:  begin src_a = dreg.d_rA; src_b = RESP; dst_e = RESP; end
            I_POPL:   begin src_a = RESP; src_b = RESP; dst_e = RESP; dst_m = dreg.d_rA; end
            I_CALL:   begin src_b = RESP; dst_e = RESP; end
            I_RET:    begin src_a = RESP; src_b = RESP; dst_e = RESP; end
            default:  ;
        endcase
    end

    y86_regfile_p #(.XLEN(XLEN), .NREG(NREG), .RID_W(RID_W)) u_regfile (
        .clk       (clk),
        .resetn    (reset),
        .rd_a_id   (src_a),
        .rd_a_data (rf_a),
        .rd_b_id   (src_b),
        .rd_b_data (rf_b),
        .wr_e_id   (w_dstE),
        .wr_e_data (w_valE),
        .wr_m_id   (w_dstM),
        .wr_m_data (w_valM)
    );

    // Youngest producer wins; W forwarding covers same-cycle regfile writes.
    function automatic logic [XLEN-1:0] fwd(
        input logic [RID_W-1:0] src, input logic [XLEN-1:0] rf,
        input logic [RID_W-1:0] ed, input logic [XLEN-1:0] ev,
        input logic [RID_W-1:0] mdm, input logic [XLEN-1:0] mvm,
        input logic [RID_W-1:0] mde, input logic [XLEN-1:0] mve,
        input logic [RID_W-1:0] wdm, input logic [XLEN-1:0] wvm,
        input logic [RID_W-1:0] wde, input logic [XLEN-1:0] wve);
        if (src == RN)  return '0;
        if (src == ed)  return ev;
        if (src == mdm) return mvm;
        if (src == mde) return mve;
        if (src == wdm) return wvm;
        if (src == wde) return wve;
        return rf;
    endfunction

    always_comb begin
        val_b = fwd(src_b, rf_b, e_dstE, e_valE, m_dstM, m_valM, m_dstE, m_valE,
                    w_dstM, w_valM, w_dstE, w_valE);
        if (dreg.d_icode == I_CALL || dreg.d_icode == I_JXX)
            val_a = dreg.d_valP;
        else
            val_a = fwd(src_a, rf_a, e_dstE, e_valE, m_dstM, m_valM, m_dstE, m_valE,
                        w_dstM, w_valM, w_dstE, w_valE);
    end

    assign lu = dreg.d_valid && ctl_q.valid && is_load(ctl_q.icode) && (dstm_q != RN)
                && ((dstm_q == src_a) || (dstm_q == src_b));

    always_comb begin
        logic load_bubble, load_instr;
        load_bubble  = 1'b0;
        load_instr   = 1'b0;
        d_ready_c    = 1'b0;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            load_bubble  = 1'b1;
            d_ready_c    = 1'b1;
            bubble_cnt_d = bubble_cnt_q + CNT_W'(bubble_cnt_q != '1);
        end else if (!ereg.e_ready) begin
            d_ready_c    = 1'b0;
        end else if (lu) begin
            load_bubble  = 1'b1;
            stall_cnt_d  = stall_cnt_q + CNT_W'(stall_cnt_q != '1);
            bubble_cnt_d = bubble_cnt_q + CNT_W'(bubble_cnt_q != '1);
        end else if (dreg.d_valid) begin
            load_instr   = 1'b1;
            d_ready_c    = 1'b1;
        end else begin
            load_bubble  = 1'b1;
            d_ready_c    = 1'b1;
        end

        ctl_d  = ctl_q;
        valc_d = valc_q;
        vala_d = vala_q;
        valb_d = valb_q;
        srca_d = srca_q;
        srcb_d = srcb_q;
        dste_d = dste_q;
        dstm_d = dstm_q;
        if (load_bubble) begin
            ctl_d  = E_CTL_BUBBLE;
            valc_d = '0;
            vala_d = '0;
            valb_d = '0;
            srca_d = RN;
            srcb_d = RN;
            dste_d = RN;
            dstm_d = RN;
        end else if (load_instr) begin
            ctl_d  = '{valid: 1'b1, icode: dreg.d_icode, ifun: dreg.d_ifun};
            valc_d = dreg.d_valC;
            vala_d = val_a;
            valb_d = val_b;
            srca_d = src_a;
            srcb_d = src_b;
            dste_d = dst_e;
            dstm_d = dst_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctl_q        <= E_CTL_BUBBLE;
            valc_q       <= '0;
            vala_q       <= '0;
            valb_q       <= '0;
            srca_q       <= RN;
            srcb_q       <= RN;
            dste_q       <= RN;
            dstm_q       <= RN;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ctl_q        <= ctl_d;
            valc_q       <= valc_d;
            vala_q       <= vala_d;
            valb_q       <= valb_d;
            srca_q       <= srca_d;
            srcb_q       <= srcb_d;
            dste_q       <= dste_d;
            dstm_q       <= dstm_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign dreg.d_ready = d_ready_c;
    assign ereg.e_valid = ctl_q.valid;
    assign ereg.e_icode = ctl_q.icode;
    assign ereg.e_ifun  = ctl_q.ifun;
    assign ereg.e_valC  = valc_q;
    assign ereg.e_valA  = vala_q;
    assign ereg.e_valB  = valb_q;
    assign ereg.e_srcA  = srca_q;
    assign ereg.e_srcB  = srcb_q;
    assign ereg.e_dstE  = dste_q;
    assign ereg.e_dstM  = dstm_q;
    assign stall_cnt    = stall_cnt_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_y86_decode_stage.sv
// tb/tb_y86_decode_stage.sv - directed-vector bench for y86_decode_stage
module tb_y86_decode_stage;

    logic        clk;
    logic        reset;
    logic [3:0]  e_dstE, m_dstE, m_dstM, w_dstE, w_dstM;
    logic [31:0] e_valE, m_valE, m_valM, w_valE, w_valM;
    logic        flush;
    logic [15:0] stall_cnt, bubble_cnt;
    int          errs, checks;

    y86_dreg_if #(.XLEN(32), .RID_W(4)) dif ();
    y86_ereg_if #(.XLEN(32), .RID_W(4)) eif ();

    y86_decode_stage #(.XLEN(32), .NREG(8), .RID_W(4), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .dreg       (dif),
        .e_dstE     (e_dstE),
        .e_valE     (e_valE),
        .m_dstE     (m_dstE),
        .m_valE     (m_valE),
        .m_dstM     (m_dstM),
        .m_valM     (m_valM),
        .w_dstE     (w_dstE),
        .w_valE     (w_valE),
        .w_dstM     (w_dstM),
        .w_valM     (w_valM),
        .flush      (flush),
        .ereg       (eif),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [31:0] valc, input logic [31:0] valp);
        dif.d_valid = 1'b1;
        dif.d_icode = icode;
        dif.d_ifun  = 4'h0;
        dif.d_rA    = ra;
        dif.d_rB    = rb;
        dif.d_valC  = valc;
        dif.d_valP  = valp;
        #1;
    endtask

    initial begin
        errs = 0;
        checks = 0;
        reset = 1'b0;
        flush = 1'b0;
        eif.e_ready = 1'b1;
        dif.d_valid = 1'b0;
        dif.d_icode = 4'h1;
        dif.d_ifun = 4'h0;
        dif.d_rA = 4'hF;
        dif.d_rB = 4'hF;
        dif.d_valC = '0;
        dif.d_valP = '0;
        e_dstE = 4'hF; m_dstE = 4'hF; m_dstM = 4'hF; w_dstE = 4'hF; w_dstM = 4'hF;
        e_valE = '0; m_valE = '0; m_valM = '0; w_valE = '0; w_valM = '0;
        tick;
        tick;
        chk("rst_e_valid", eif.e_valid, 0);
        chk("rst_e_icode", eif.e_icode, 4'h1);
        chk("rst_e_srcA", eif.e_srcA, 4'hF);
        chk("rst_e_dstE", eif.e_dstE, 4'hF);
        chk("rst_e_valA", eif.e_valA, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_bubble", bubble_cnt, 0);
        reset = 1'b1;

        // IRMOVL $0x10, r2
        set_d(4'h3, 4'hF, 4'h2, 32'h10, 32'h16);
        chk("irmovl_d_ready", dif.d_ready, 1);
        tick;
        chk("irmovl_e_valid", eif.e_valid, 1);
        chk("irmovl_e_icode", eif.e_icode, 4'h3);
        chk("irmovl_e_dstE", eif.e_dstE, 4'h2);
        chk("irmovl_e_valC", eif.e_valC, 32'h10);
        chk("irmovl_e_srcA", eif.e_srcA, 4'hF);
        chk("irmovl_e_srcB", eif.e_srcB, 4'hF);
        chk("irmovl_e_dstM", eif.e_dstM, 4'hF);
        chk("irmovl_stall", stall_cnt, 0);
        chk("irmovl_bubble", bubble_cnt, 0);

        // OPL r1,r3 with E and W both producing r1: E wins
        e_dstE = 4'h1; e_valE = 32'hAA; w_dstE = 4'h1; w_valE = 32'h55;
        set_d(4'h6, 4'h1, 4'h3, 0, 0);
        tick;
        chk("fwd_e_valA", eif.e_valA, 32'hAA);
        chk("fwd_e_valB", eif.e_valB, 0);
        chk("fwd_e_srcA", eif.e_srcA, 4'h1);
        chk("fwd_e_dstE", eif.e_dstE, 4'h3);
        e_dstE = 4'hF;
        #1;
        tick;
        chk("fwd_w_valA", eif.e_valA, 32'h55);
        w_dstE = 4'hF; w_valE = '0;
        set_d(4'h6, 4'h1, 4'h1, 0, 0);
        tick;
        chk("rf_r1_valA", eif.e_valA, 32'h55);
        chk("rf_r1_valB", eif.e_valB, 32'h55);

        // load-use: MRMOVL into r5, then OPL reading r5
        set_d(4'h5, 4'h5, 4'hF, 32'h8, 0);
        tick;
        chk("lu_mr_dstM", eif.e_dstM, 4'h5);
        set_d(4'h6, 4'h5, 4'h2, 0, 0);
        chk("lu_d_ready", dif.d_ready, 0);
        tick;
        chk("lu_bubble_valid", eif.e_valid, 0);
        chk("lu_bubble_icode", eif.e_icode, 4'h1);
        chk("lu_stall", stall_cnt, 1);
        chk("lu_bubble", bubble_cnt, 1);
        m_dstM = 4'h5; m_valM = 32'h77;
        #1;
        chk("lu_release_ready", dif.d_ready, 1);
        tick;
        chk("lu_opl_valid", eif.e_valid, 1);
        chk("lu_opl_valA", eif.e_valA, 32'h77);
        m_dstM = 4'hF; m_valM = '0;

        // flush wins over a pending load-use
        set_d(4'h5, 4'h5, 4'hF, 0, 0);
        tick;
        set_d(4'h6, 4'h5, 4'h2, 0, 0);
        flush = 1'b1;
        #1;
        chk("flush_d_ready", dif.d_ready, 1);
        tick;
        flush = 1'b0;
        chk("flush_e_valid", eif.e_valid, 0);
        chk("flush_bubble", bubble_cnt, 2);
        chk("flush_stall", stall_cnt, 1);

        // backpressure for 3 cycles
        set_d(4'h3, 4'hF, 4'h7, 32'h33, 0);
        tick;
        set_d(4'h3, 4'hF, 4'h6, 32'h44, 0);
        eif.e_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_d_ready", dif.d_ready, 0);
            tick;
            chk("bp_hold_valid", eif.e_valid, 1);
            chk("bp_hold_valC", eif.e_valC, 32'h33);
            chk("bp_hold_dstE", eif.e_dstE, 4'h7);
        end
        chk("bp_bubble", bubble_cnt, 2);
        eif.e_ready = 1'b1;
        #1;
        chk("bp_release_ready", dif.d_ready, 1);
        tick;
        chk("bp_new_valC", eif.e_valC, 32'h44);
        chk("bp_new_dstE", eif.e_dstE, 4'h6);

        // dual write to r6: M port wins
        dif.d_valid = 1'b0;
        w_dstM = 4'h6; w_valM = 32'h1; w_dstE = 4'h6; w_valE = 32'h2;
        tick;
        w_dstM = 4'hF; w_valM = '0; w_dstE = 4'hF; w_valE = '0;
        set_d(4'h6, 4'h6, 4'h6, 0, 0);
        tick;
        chk("wprio_valA", eif.e_valA, 32'h1);
        chk("wprio_valB", eif.e_valB, 32'h1);
        chk("idle_bubble", bubble_cnt, 2);

        // CALL: valA is valP, ESP as srcB/dstE
        set_d(4'h8, 4'hF, 4'hF, 32'h200, 32'h100);
        tick;
        chk("call_valA", eif.e_valA, 32'h100);
        chk("call_srcB", eif.e_srcB, 4'h4);
        chk("call_dstE", eif.e_dstE, 4'h4);
        chk("call_srcA", eif.e_srcA, 4'hF);

        // reset mid-stream overrides flush and a valid D
        set_d(4'h3, 4'hF, 4'h2, 32'h99, 0);
        flush = 1'b1;
        reset = 1'b0;
        tick;
        chk("mrst_e_valid", eif.e_valid, 0);
        chk("mrst_e_icode", eif.e_icode, 4'h1);
        chk("mrst_e_dstE", eif.e_dstE, 4'hF);
        chk("mrst_e_valC", eif.e_valC, 0);
        chk("mrst_stall", stall_cnt, 0);
        chk("mrst_bubble", bubble_cnt, 0);
        reset = 1'b1;
        flush = 1'b0;
        set_d(4'h6, 4'h6, 4'h6, 0, 0);
        tick;
        chk("mrst_rf_cleared", eif.e_valA, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/y86_decode_stage.md
Name: y86_decode_stage

Overview:
Next-generation Y86 decode stage. It combines a parametrised register file, operand forwarding from E/M/W, load-use hazard detection with stall, and a D/E pipeline register with bubble, flush and backpressure handling. It sits between fetch (D register) and execute. Unlike the current decode, it owns its E-side pipeline register and generates its own stall and bubble.

Parameters:
XLEN, 32, data width of registers and forwarded values
NREG, 8, architectural registers, IDs 0..NREG-1; ID 4'hF is R_NONE
RID_W, 4, register ID width; NREG must be at most 15
CNT_W, 16, width of the saturating stall/bubble performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
d_valid  in  1  D holds a valid instruction
d_ready  out  1  decode consumes D this cycle; 0 stalls fetch
d_icode  in  4  instruction code
d_ifun  in  4  function code
d_rA  in  RID_W  rA field
d_rB  in  RID_W  rB field
d_valC  in  XLEN  constant
d_valP  in  XLEN  next PC
e_dstE  in  RID_W  E-stage destination for valE (after cmov Cnd)
e_valE  in  XLEN  ALU result
m_dstE  in  RID_W  M-stage E destination
m_valE  in  XLEN  M-stage valE
m_dstM  in  RID_W  M-stage M destination
m_valM  in  XLEN  memory read data
w_dstE  in  RID_W  writeback E destination; R_NONE means no write
w_valE  in  XLEN  writeback valE
w_dstM  in  RID_W  writeback M destination; R_NONE means no write
w_valM  in  XLEN  writeback valM
flush  in  1  branch mispredict or ret squash
e_ready  in  1  execute accepts the E register
e_valid  out  1  E register holds a real instruction
e_icode  out  4  E register icode; I_NOP on bubble
e_ifun  out  4  E register ifun
e_valC  out  XLEN  E register valC
e_valA  out  XLEN  E register valA
e_valB  out  XLEN  E register valB
e_srcA  out  RID_W  E register srcA
e_srcB  out  RID_W  E register srcB
e_dstE  out  RID_W  E register dstE
e_dstM  out  RID_W  E register dstM
stall_cnt  out  CNT_W  count of load-use stall cycles, saturating
bubble_cnt  out  CNT_W  count of bubbles inserted, saturating

Behaviour:
- Reset (reset==0 at a clk edge):
  - all registers cleared; e_valid=0, e_icode=I_NOP, src/dst fields=R_NONE, values=0.
  - both counters=0.
  - reset overrides flush, stall and writes issued in the same cycle.
- Decode tables:
  - srcA: rA for RRMOVL/RMMOVL/OPL/PUSHL; R_ESP for POPL/RET; else R_NONE.
  - srcB: R_ESP for PUSHL/POPL/CALL/RET; rB for OPL/RMMOVL/MRMOVL; else R_NONE.
  - dstE: rB for RRMOVL/IRMOVL/OPL; R_ESP for PUSHL/POPL/CALL/RET; else R_NONE.
  - dstM: rA for MRMOVL/POPL; else R_NONE.
- Register file:
  - NREG x XLEN; two combinational reads.
  - Writes on clk: port M (w_dstM, w_valM) and port E (w_dstE, w_valE); ID >= NREG or R_NONE means no write.
  - If both ports target the same ID, M wins.
  - Register IDs >= NREG other than R_NONE read as 0.
- valA selection, first match wins:
  - CALL/JXX: d_valP.
  - srcA==e_dstE: e_valE.
  - srcA==m_dstM: m_valM.
  - srcA==m_dstE: m_valE.
  - srcA==w_dstM: w_valM.
  - srcA==w_dstE: w_valE.
  - otherwise the regfile.
  - A source of R_NONE never matches; valA is 0 in that case.
- valB: same priority as valA without the CALL/JXX term.
- Load-use hazard:
  - lu = d_valid & e_valid & (e_icode is MRMOVL or POPL) & e_dstM!=R_NONE & (e_dstM==srcA or e_dstM==srcB).
- Cycle actions, in priority order:
  1. flush: E register loads a bubble; d_ready=1, so D is discarded; bubble_cnt++.
  2. !e_ready: E register holds; d_ready=0; no counters change.
  3. lu: E register loads a bubble; d_ready=0; stall_cnt++ and bubble_cnt++.
  4. d_valid: E register loads the decoded instruction; d_ready=1.
  5. otherwise: E register loads a bubble (e_valid=0); d_ready=1; no counter change.
- d_ready is combinational from the inputs and the E register only. Latency is 1 cycle from D acceptance to e_valid.
- Counters saturate at all ones.
- A register written in cycle N and read in the same cycle is served by W forwarding; the regfile read in cycle N+1 returns the new value.

Decomposition:
- Shared package y86_define: I_* icodes, R_ESP, R_NONE, the bubble constants, and the E-register field struct.
- One sub-module: y86_regfile_p, parametrised on XLEN and NREG, with 2 read ports, 2 write ports, and M-over-E write priority.
- The forwarding mux, hazard logic and pipeline register stay in y86_decode_stage.

Test Plan:
- Reset then d_valid IRMOVL rB=2, valC=0x10 -> next cycle e_valid=1, e_dstE=2, e_valC=0x10, e_srcA=e_srcB=R_NONE; counters 0.
- OPL rA=1 rB=3 with e_dstE=1, e_valE=0xAA and w_dstE=1, w_valE=0x55 -> e_valA=0xAA; same case with e_dstE=R_NONE -> e_valA=0x55.
- MRMOVL rA=5 in E, then OPL rA=5 in D -> one cycle with d_ready=0 and an E bubble, stall_cnt=1; next cycle OPL accepted with valA taken from m_valM.
- flush asserted together with d_valid=1 and lu=1 -> E register becomes a bubble, d_ready=1, bubble_cnt+1, stall_cnt unchanged.
- e_ready=0 for 3 cycles with d_valid=1 -> E outputs held constant, d_ready=0 throughout; on release the D instruction appears one cycle later.
- w_dstM=w_dstE=6 with values 0x1 and 0x2 -> a later read of r6 returns 0x1; reset==0 mid-stream -> all outputs at reset values on the next edge.
